radix2_divider: RTL and testbench

- Iterative restoring divider implementing RISC-V M-extension div, divu, rem and remu.
- Counterpart to the Dadda multiplier path: the multiplier builds a product from partial products; this block recovers quotient/remainder one bit per cycle.
- Sits beside the multiplier in the execute stage; shares the same start / busy / result-valid style of handshake with the pipeline controller.

---
 rtl/radix2_divider_pkg.sv | 29 ++
 rtl/radix2_divider_step.sv | 25 ++
 rtl/radix2_divider.sv | 126 ++++++++++++
 tb/tb_radix2_divider.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/radix2_divider_pkg.sv
// Shared types for the radix-2 divider: RISC-V M-extension divide funct3 codes and FSM states.
// Pure declarations, no timing or handshake behaviour.
package radix2_divider_pkg;

  typedef enum logic [2:0] {
    OP_DIV  = 3'b100,
    OP_DIVU = 3'b101,
    OP_REM  = 3'b110,
    OP_REMU = 3'b111
  } div_funct3_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_t;

  // funct3[0]=0 selects the signed flavour, funct3[1]=0 selects quotient over remainder.
  function automatic logic is_signed_op(input div_funct3_t op);
    return ~op[0];
  endfunction

  function automatic logic is_div_op(input div_funct3_t op);
    return ~op[1];
  endfunction

endpackage

// File: rtl/radix2_divider_step.sv
// One combinational restoring-division step: shift in the next dividend bit, trial subtract, select.
// Zero latency; no handshake, the owning FSM decides when the step result is registered.
module radix2_divider_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             trial_unused;

  // The shifted partial remainder keeps its top bit so unsigned divisors above 2^(WIDTH-1) still work.
  assign shifted      = {rem_in, q_in[WIDTH-1]};
  assign trial        = {1'b0, shifted} - {2'b00, divisor};
  assign trial_unused = trial[WIDTH];

  assign rem_out = trial[WIDTH+1] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign q_out   = {q_in[WIDTH-2:0], ~trial[WIDTH+1]};

endmodule

// File: rtl/radix2_divider.sv
// Iterative restoring divider for div/divu/rem/remu; WIDTH+3 cycles from start to o_valid, 2 for div-by-zero/overflow.
// Result is held in DONE until o_valid & o_ready; start is only taken in IDLE and flush aborts from any state.
module radix2_divider
  import radix2_divider_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  div_funct3_t      div_op,
  input  logic             start,
  output logic             i_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             busy,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  div_state_t       state;
  div_funct3_t      op_r;
  logic [WIDTH-1:0] dvd_r;
  logic [WIDTH-1:0] dvs_r;
  logic [WIDTH-1:0] abs_dvs;
  logic [WIDTH-1:0] rem_acc;
  logic [WIDTH-1:0] q_acc;
  logic             neg_q;
  logic             neg_r;
  logic [CNT_W-1:0] cnt;

  logic             op_signed;
  logic             op_div;
  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] abs_dvd;
  logic             div_zero;
  logic             sgn_ovf;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_q;

  assign op_signed = is_signed_op(op_r);
  assign op_div    = is_div_op(op_r);
  assign dvd_neg   = op_signed & dvd_r[WIDTH-1];
  assign dvs_neg   = op_signed & dvs_r[WIDTH-1];
  assign abs_dvd   = dvd_neg ? -dvd_r : dvd_r;
  assign div_zero  = (dvs_r == '0);
  assign sgn_ovf   = op_signed && (dvd_r == {1'b1, {(WIDTH-1){1'b0}}}) && (dvs_r == '1);

  radix2_divider_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_acc),
    .q_in    (q_acc),
    .divisor (abs_dvs),
    .rem_out (step_rem),
    .q_out   (step_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      op_r    <= div_funct3_t'(3'b000);
      dvd_r   <= '0;
      dvs_r   <= '0;
      abs_dvs <= '0;
      rem_acc <= '0;
      q_acc   <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      cnt     <= '0;
      result  <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_r  <= div_op;
            dvd_r <= dividend;
            dvs_r <= divisor;
            state <= PREP;
          end
        end
        PREP: begin
          neg_q   <= dvd_neg ^ dvs_neg;
          neg_r   <= dvd_neg;
          abs_dvs <= dvs_neg ? -dvs_r : dvs_r;
          q_acc   <= abs_dvd;
          rem_acc <= '0;
          cnt     <= '0;
          if (div_zero) begin
            result <= op_div ? '1 : dvd_r;
            state  <= DONE;
          end else if (sgn_ovf) begin
            result <= op_div ? dvd_r : '0;
            state  <= DONE;
          end else begin
            state <= ITER;
          end
        end
        ITER: begin
          rem_acc <= step_rem;
          q_acc   <= step_q;
          cnt     <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          if (op_div) result <= neg_q ? -q_acc : q_acc;
          else        result <= neg_r ? -rem_acc : rem_acc;
          state <= DONE;
        end
        DONE: begin
          if (o_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign i_ready = (state == IDLE);
  assign busy    = (state == PREP) || (state == ITER) || (state == FIX);
  assign o_valid = (state == DONE);

endmodule

// File: tb/tb_radix2_divider.sv
// Randomised and directed bench for radix2_divider against an arithmetic reference model.
module tb_radix2_divider;
  import radix2_divider_pkg::*;

  localparam int W = 32;

  logic        clk = 1'b0;
  logic        rst, start, flush, o_ready;
  div_funct3_t div_op;
  logic [W-1:0] dividend, divisor, result;
  logic        i_ready, busy, o_valid;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] last_result;

  always #5 clk = ~clk;

  radix2_divider #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .div_op   (div_op),
    .start    (start),
    .i_ready  (i_ready),
    .dividend (dividend),
    .divisor  (divisor),
    .flush    (flush),
    .busy     (busy),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .result   (result)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic is_div(input div_funct3_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_sgn(input div_funct3_t op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  // RISC-V semantics from plain 64-bit arithmetic; the overflow case falls out of truncation to 32 bits.
  function automatic logic [W-1:0] model(input div_funct3_t op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, q, r;
    if (b == '0) return is_div(op) ? '1 : a;
    sa = is_sgn(op) ? longint'($signed(a)) : longint'(a);
    sb = is_sgn(op) ? longint'($signed(b)) : longint'(b);
    q = sa / sb;
    r = sa % sb;
    return is_div(op) ? q[W-1:0] : r[W-1:0];
  endfunction

  function automatic int model_lat(input div_funct3_t op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == '0) return 2;
    if (is_sgn(op) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return W + 3;
  endfunction

  // Presents start for exactly one cycle; returns at the negedge inside cycle 1.
  task automatic issue(input div_funct3_t op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    div_op   = op;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_cycle(inout int cyc, input int target);
    while (cyc < target) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input div_funct3_t op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int hold);
    logic [W-1:0] exp;
    int cyc;
    exp     = model(op, a, b);
    o_ready = (hold == 0);
    check({tag, "_iready"}, W'(i_ready), W'(1));
    issue(op, a, b);
    cyc = 1;
    while (!o_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_lat"}, W'(cyc), W'(model_lat(op, a, b)));
    check({tag, "_res"}, result, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_vld"}, W'(o_valid), W'(1));
      check({tag, "_hold_res"}, result, exp);
    end
    o_ready = 1'b1;
    @(negedge clk);
    check({tag, "_pulse"}, W'(o_valid), W'(0));
    check({tag, "_idle"}, W'(i_ready), W'(1));
    last_result = exp;
  endtask

  initial begin
    int cyc;
    logic seen;
    div_funct3_t op;
    logic [W-1:0] a, b;

    rst = 1'b1; start = 1'b0; flush = 1'b0; o_ready = 1'b0;
    div_op = OP_DIV; dividend = '0; divisor = '0;
    last_result = '0;
    repeat (3) @(negedge clk);
    check("rst_iready", W'(i_ready), W'(1));
    check("rst_busy", W'(busy), W'(0));
    check("rst_ovalid", W'(o_valid), W'(0));
    check("rst_result", result, '0);
    rst = 1'b0;

    run_op("div_20_m3", OP_DIV, 32'h14, 32'hFFFF_FFFD, 0);
    run_op("rem_20_m3", OP_REM, 32'h14, 32'hFFFF_FFFD, 0);
    run_op("divu_max_2", OP_DIVU, 32'hFFFF_FFFF, 32'h2, 0);
    run_op("remu_max_2", OP_REMU, 32'hFFFF_FFFF, 32'h2, 0);
    run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'h2, 0);
    run_op("div_by0", OP_DIV, 32'h1234_5678, 32'h0, 0);
    run_op("rem_by0", OP_REM, 32'h1234_5678, 32'h0, 0);
    run_op("divu_by0", OP_DIVU, 32'h1234_5678, 32'h0, 0);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("divu_big", OP_DIVU, 32'hFFFF_FFFE, 32'h8000_0001, 0);
    run_op("bp_div", OP_DIV, 32'd1000, 32'd7, 10);

    // Flush mid-iteration: idle next cycle, no valid, result untouched.
    o_ready = 1'b1;
    issue(OP_DIV, 32'd100, 32'd7);
    cyc = 1;
    wait_cycle(cyc, 10);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_iready", W'(i_ready), W'(1));
    check("flush_busy", W'(busy), W'(0));
    check("flush_ovalid", W'(o_valid), W'(0));
    check("flush_result", result, last_result);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen |= o_valid;
    end
    check("flush_no_valid", W'(seen), W'(0));
    run_op("after_flush", OP_DIV, 32'd100, 32'd7, 0);

    // A second start during ITER must be ignored entirely.
    o_ready = 1'b1;
    issue(OP_DIV, 32'd100, 32'd7);
    cyc = 1;
    wait_cycle(cyc, 5);
    div_op = OP_REM; dividend = 32'd50; divisor = 32'd3; start = 1'b1;
    @(negedge clk);
    cyc++;
    start = 1'b0;
    while (!o_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("ign_lat", W'(cyc), W'(W + 3));
    check("ign_res", result, 32'd14);
    last_result = 32'd14;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen |= o_valid;
    end
    check("ign_no_second", W'(seen), W'(0));

    for (int n = 0; n < 150; n++) begin
      op = div_funct3_t'(3'(4 + $urandom_range(0, 3)));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
        3: b = b >> $urandom_range(0, 31);
        default: ;
      endcase
      run_op("rand", op, a, b, $urandom_range(0, 2));
    end

    // Synchronous reset mid-operation.
    o_ready = 1'b1;
    issue(OP_DIV, 32'd100, 32'd7);
    cyc = 1;
    wait_cycle(cyc, 15);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_iready", W'(i_ready), W'(1));
    check("mid_rst_busy", W'(busy), W'(0));
    check("mid_rst_ovalid", W'(o_valid), W'(0));
    check("mid_rst_result", result, '0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen |= o_valid;
    end
    check("mid_rst_no_valid", W'(seen), W'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
